calc_operand_entry: RTL and testbench
=====================================

CALC_OPERAND_ENTRY -- requirements
Module: calc_operand_entry

Interface
REQ-001 The block SHALL have input clk, 1 bit, the system clock; all state updates on its rising edge.
REQ-002 The block SHALL have input reset, 1 bit, synchronous, active-high.
REQ-003 The block SHALL have input key_valid, 1 bit, a one-cycle strobe from the keypad decoder meaning key_code is valid this cycle.
REQ-004 The block SHALL have input key_code, 4 bits: 0-9 digit, 4'hA add, 4'hB subtract, 4'hC equals, 4'hD clear, 4'hE-4'hF unused.
REQ-005 The block SHALL have input num1_en, 1 bit, from the operation control FSM: first-operand entry allowed.
REQ-006 The block SHALL have input num2_en, 1 bit, from the operation control FSM: second-operand entry allowed.
REQ-007 The block SHALL have output op_a, 14 bits, the binary value of the first operand, 0-9999.
REQ-008 The block SHALL have output op_b, 14 bits, the binary value of the second operand, 0-9999.
REQ-009 The block SHALL have output operando_en, 1 bit, a one-cycle pulse: operator key accepted.
REQ-010 The block SHALL have output que_operacion, 2 bits: 2'b01 add, 2'b10 subtract; held until the next accepted operator key.
REQ-011 The block SHALL have output igual_en, 1 bit, a one-cycle pulse: equals key accepted.
REQ-012 The block SHALL have output clr_pulse, 1 bit, a one-cycle pulse: clear key accepted.
REQ-013 The block SHALL have output ovf_pulse, 1 bit, a one-cycle pulse: digit rejected because the operand already holds 4 digits.

Function
REQ-014 All outputs SHALL be registered; every response to a key SHALL appear exactly one cycle after the cycle in which key_valid=1.
REQ-015 The block SHALL keep digit counters cnt_a and cnt_b, 3 bits each, range 0-4.
REQ-016 Target selection SHALL be: num1_en=1 -> op_a (num1_en has priority when both are 1); else num2_en=1 -> op_b; else no target.
REQ-017 On a digit d with a target whose counter is below 4, the block SHALL set target <= target*10 + d (computed as (x<<3)+(x<<1)+d, 14-bit) and increment that counter.
REQ-018 On a digit with a target counter of 4, the block SHALL leave the operand and counter unchanged and assert ovf_pulse.
REQ-019 On a digit with no target, the block SHALL leave all state unchanged and assert no pulse.
REQ-020 On a rising edge of num1_en (0 at the previous clock, 1 now), the block SHALL clear op_a and cnt_a; on a rising edge of num2_en it SHALL clear op_b and cnt_b.
REQ-021 If an enable rising edge and a digit occur in the same cycle, the clear SHALL apply first, so the operand becomes d and its counter becomes 1.
REQ-022 On 4'hA or 4'hB with num1_en=1 and cnt_a>=1, the block SHALL set que_operacion and pulse operando_en; otherwise it SHALL ignore the key.
REQ-023 On 4'hC with num2_en=1 and cnt_b>=1, the block SHALL pulse igual_en; otherwise it SHALL ignore the key.
REQ-024 On 4'hD, the block SHALL clear op_a, op_b, cnt_a, cnt_b and que_operacion, and pulse clr_pulse, regardless of the enables.
REQ-025 Key codes 4'hE-4'hF SHALL be ignored.
REQ-026 Pulses SHALL be mutually exclusive and SHALL last exactly one cycle; back-to-back key_valid cycles SHALL each be processed independently.
REQ-027 Operands SHALL never wrap: the maximum value is 9999, enforced by the 4-digit limit.

Reset
REQ-028 While reset=1, the block SHALL clear op_a, op_b, cnt_a, cnt_b, que_operacion and all pulses to 0, and clear the stored previous values of num1_en/num2_en to 0.
REQ-029 Reset SHALL take priority over any concurrent key_valid, and a partially entered operand SHALL be discarded.

Verification
REQ-030 Bench: reset, num1_en=1, keys 1,2,3 -> op_a=123, cnt_a=3, no pulses.
REQ-031 Bench: num1_en=1, keys 9,9,9,9,5 -> op_a=9999 and ovf_pulse on the fifth key only.
REQ-032 Bench: op_a=12, key 4'hB -> operando_en pulse one cycle later, que_operacion=2'b10; key 4'hA with cnt_a=0 -> no pulse.
REQ-033 Bench: num1_en 1->0, num2_en 0->1 together with digit 7 in the same cycle -> op_b=7, cnt_b=1; then 4'hC -> igual_en pulse.
REQ-034 Bench: mid-entry op_a=45, key 4'hD -> clr_pulse, op_a=op_b=0; a separate reset asserted during entry -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/calc_operand_entry.sv
// Calculator operand entry: accumulates keypad digits into two
// 4-digit binary operands and decodes operator/equals/clear keys.
module calc_operand_entry (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        num1_en,
  input  logic        num2_en,
  output logic [13:0] op_a,
  output logic [13:0] op_b,
  output logic        operando_en,
  output logic [1:0]  que_operacion,
  output logic        igual_en,
  output logic        clr_pulse,
  output logic        ovf_pulse
);

  logic [13:0] a_q, a_d, b_q, b_d;
  logic [2:0]  ca_q, ca_d, cb_q, cb_d;
  logic [1:0]  op_q, op_d;
  logic        n1_q, n2_q;
  logic        opp_q, opp_d, eq_q, eq_d;
  logic        clr_q, clr_d, ovf_q, ovf_d;
  logic        is_dig, is_op, is_eq, is_clr;

  assign is_dig = key_valid && (key_code <= 4'd9);
  assign is_op  = key_valid &&
                  (key_code == 4'hA || key_code == 4'hB);
  assign is_eq  = key_valid && (key_code == 4'hC);
  assign is_clr = key_valid && (key_code == 4'hD);

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    ca_d  = ca_q;
    cb_d  = cb_q;
    op_d  = op_q;
    opp_d = 1'b0;
    eq_d  = 1'b0;
    clr_d = 1'b0;
    ovf_d = 1'b0;
    // Entry-enable rising edges restart the operand before any key acts
    if (num1_en && !n1_q) begin
      a_d  = '0;
      ca_d = '0;
    end
    if (num2_en && !n2_q) begin
      b_d  = '0;
      cb_d = '0;
    end
    unique case (1'b1)
      is_dig: begin
        if (num1_en) begin
          if (ca_d < 3'd4) begin
            a_d  = (a_d << 3) + (a_d << 1) + {10'd0, key_code};
            ca_d = ca_d + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (num2_en) begin
          if (cb_d < 3'd4) begin
            b_d  = (b_d << 3) + (b_d << 1) + {10'd0, key_code};
            cb_d = cb_d + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      is_op: begin
        if (num1_en && ca_d != 3'd0) begin
          op_d  = key_code[0] ? 2'b10 : 2'b01;
          opp_d = 1'b1;
        end
      end
      is_eq: begin
        if (num2_en && cb_d != 3'd0)
          eq_d = 1'b1;
      end
      is_clr: begin
        a_d   = '0;
        b_d   = '0;
        ca_d  = '0;
        cb_d  = '0;
        op_d  = '0;
        clr_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      ca_q  <= '0;
      cb_q  <= '0;
      op_q  <= '0;
      n1_q  <= 1'b0;
      n2_q  <= 1'b0;
      opp_q <= 1'b0;
      eq_q  <= 1'b0;
      clr_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      ca_q  <= ca_d;
      cb_q  <= cb_d;
      op_q  <= op_d;
      n1_q  <= num1_en;
      n2_q  <= num2_en;
      opp_q <= opp_d;
      eq_q  <= eq_d;
      clr_q <= clr_d;
      ovf_q <= ovf_d;
    end
  end

  assign op_a          = a_q;
  assign op_b          = b_q;
  assign que_operacion = op_q;
  assign operando_en   = opp_q;
  assign igual_en      = eq_q;
  assign clr_pulse     = clr_q;
  assign ovf_pulse     = ovf_q;

endmodule

// File: tb/tb_calc_operand_entry.sv
// Randomized and directed checks of calc_operand_entry against
// a decimal-arithmetic reference model.
module tb_calc_operand_entry;

  logic        clk = 0;
  logic        reset = 1;
  logic        key_valid = 0;
  logic [3:0]  key_code = 0;
  logic        num1_en = 0;
  logic        num2_en = 0;
  logic [13:0] op_a, op_b;
  logic        operando_en, igual_en, clr_pulse, ovf_pulse;
  logic [1:0]  que_operacion;

  int total = 0;
  int bad = 0;

  int ma, mb, ca, cb, mop;
  bit pn1, pn2, e_opp, e_eq, e_clr, e_ovf;

  calc_operand_entry dut (
    .clk(clk), .reset(reset), .key_valid(key_valid),
    .key_code(key_code), .num1_en(num1_en), .num2_en(num2_en),
    .op_a(op_a), .op_b(op_b), .operando_en(operando_en),
    .que_operacion(que_operacion), .igual_en(igual_en),
    .clr_pulse(clr_pulse), .ovf_pulse(ovf_pulse)
  );

  always #5 clk = ~clk;

  wire [33:0] got = {op_a, op_b, que_operacion,
                     operando_en, igual_en, clr_pulse, ovf_pulse};

  function automatic logic [33:0] expv();
    logic [13:0] a, b;
    logic [1:0] o;
    a = ma[13:0];
    b = mb[13:0];
    o = mop[1:0];
    return {a, b, o, e_opp, e_eq, e_clr, e_ovf};
  endfunction

  task automatic model(bit r, bit kv, int code, bit n1, bit n2);
    e_opp = 0; e_eq = 0; e_clr = 0; e_ovf = 0;
    if (r) begin
      ma = 0; mb = 0; ca = 0; cb = 0; mop = 0;
      pn1 = 0; pn2 = 0;
      return;
    end
    if (n1 && !pn1) begin ma = 0; ca = 0; end
    if (n2 && !pn2) begin mb = 0; cb = 0; end
    if (kv) begin
      if (code <= 9) begin
        if (n1) begin
          if (ca < 4) begin ma = ma * 10 + code; ca++; end
          else e_ovf = 1;
        end else if (n2) begin
          if (cb < 4) begin mb = mb * 10 + code; cb++; end
          else e_ovf = 1;
        end
      end else if (code == 10 || code == 11) begin
        if (n1 && ca >= 1) begin
          mop = (code == 10) ? 1 : 2;
          e_opp = 1;
        end
      end else if (code == 12) begin
        if (n2 && cb >= 1) e_eq = 1;
      end else if (code == 13) begin
        ma = 0; mb = 0; ca = 0; cb = 0; mop = 0;
        e_clr = 1;
      end
    end
    pn1 = n1;
    pn2 = n2;
  endtask

  task automatic step(bit r, bit kv, int code, bit n1, bit n2);
    @(negedge clk);
    reset = r;
    key_valid = kv;
    key_code = code[3:0];
    num1_en = n1;
    num2_en = n2;
    @(posedge clk);
    model(r, kv, code, n1, n2);
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 5, 1, 0);
    step(1, 0, 0, 0, 0);
    total++;
    if (got !== 34'd0) begin
      bad++;
      $display("FAIL reset_state got=%h want=0", got);
    end
  endtask

  task automatic test_digits();
    step(0, 0, 0, 1, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 2, 1, 0);
    step(0, 1, 3, 1, 0);
    total++;
    if (op_a !== 14'd123) begin
      bad++;
      $display("FAIL digits_123 got=%0d want=123", op_a);
    end
    total++;
    if (got !== expv()) begin
      bad++;
      $display("FAIL digits_vec got=%h want=%h", got, expv());
    end
  endtask

  task automatic test_overflow();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 9, 1, 0);
      total++;
      if (ovf_pulse !== 1'b0) begin
        bad++;
        $display("FAIL ovf_early key=%0d got=%b want=0", i, ovf_pulse);
      end
    end
    step(0, 1, 5, 1, 0);
    total++;
    if (ovf_pulse !== 1'b1 || op_a !== 14'd9999) begin
      bad++;
      $display("FAIL ovf_fifth ovf=%b op_a=%0d want 1/9999",
               ovf_pulse, op_a);
    end
    step(0, 0, 0, 1, 0);
    total++;
    if (ovf_pulse !== 1'b0) begin
      bad++;
      $display("FAIL ovf_one_cycle got=%b want=0", ovf_pulse);
    end
  endtask

  task automatic test_operator();
    step(0, 0, 0, 0, 0);
    step(0, 1, 10, 1, 0);
    total++;
    if (operando_en !== 1'b0 || que_operacion !== 2'b00) begin
      bad++;
      $display("FAIL op_cnt0 en=%b op=%b want 0/00",
               operando_en, que_operacion);
    end
    step(0, 1, 1, 1, 0);
    step(0, 1, 2, 1, 0);
    step(0, 1, 11, 1, 0);
    total++;
    if (operando_en !== 1'b1 || que_operacion !== 2'b10 ||
        op_a !== 14'd12) begin
      bad++;
      $display("FAIL op_sub en=%b op=%b a=%0d want 1/10/12",
               operando_en, que_operacion, op_a);
    end
    step(0, 0, 0, 1, 0);
    total++;
    if (operando_en !== 1'b0 || que_operacion !== 2'b10) begin
      bad++;
      $display("FAIL op_hold en=%b op=%b want 0/10",
               operando_en, que_operacion);
    end
  endtask

  task automatic test_enable_edge();
    step(0, 1, 12, 1, 0);
    total++;
    if (igual_en !== 1'b0) begin
      bad++;
      $display("FAIL eq_no_num2 got=%b want=0", igual_en);
    end
    step(0, 1, 7, 0, 1);
    total++;
    if (op_b !== 14'd7 || got !== expv()) begin
      bad++;
      $display("FAIL edge_digit got=%h want=%h", got, expv());
    end
    step(0, 1, 12, 0, 1);
    total++;
    if (igual_en !== 1'b1 || operando_en !== 1'b0) begin
      bad++;
      $display("FAIL eq_pulse eq=%b opp=%b want 1/0",
               igual_en, operando_en);
    end
  endtask

  task automatic test_clear();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 4, 1, 0);
    step(0, 1, 5, 1, 0);
    step(0, 1, 13, 0, 0);
    total++;
    if (clr_pulse !== 1'b1 || op_a !== 0 || op_b !== 0 ||
        que_operacion !== 0) begin
      bad++;
      $display("FAIL clear got=%h want=%h", got, expv());
    end
    step(0, 1, 4, 1, 0);
    step(0, 1, 6, 1, 0);
    step(1, 1, 3, 1, 0);
    total++;
    if (got !== 34'd0) begin
      bad++;
      $display("FAIL reset_mid got=%h want=0", got);
    end
  endtask

  task automatic test_random();
    bit n1 = 0, n2 = 0;
    for (int i = 0; i < 600; i++) begin
      bit r, kv;
      int code;
      if ($urandom_range(0, 9) == 0) n1 = ~n1;
      if ($urandom_range(0, 9) == 0) n2 = ~n2;
      r = ($urandom_range(0, 99) == 0);
      kv = ($urandom_range(0, 3) != 0);
      code = ($urandom_range(0, 2) != 0) ?
             $urandom_range(0, 9) : $urandom_range(10, 15);
      step(r, kv, code, n1, n2);
      total++;
      if (got !== expv()) begin
        bad++;
        $display("FAIL random_%0d got=%h want=%h", i, got, expv());
      end
    end
  endtask

  task automatic test_back_to_back();
    step(0, 0, 0, 0, 0);
    step(0, 1, 8, 0, 1);
    step(0, 1, 3, 0, 1);
    step(0, 1, 12, 0, 1);
    total++;
    if (op_b !== 14'd83 || igual_en !== 1'b1) begin
      bad++;
      $display("FAIL b2b b=%0d eq=%b want 83/1", op_b, igual_en);
    end
    step(0, 1, 14, 0, 1);
    total++;
    if (got !== expv() || igual_en !== 1'b0) begin
      bad++;
      $display("FAIL unused_key got=%h want=%h", got, expv());
    end
  endtask

  initial begin
    model(1, 0, 0, 0, 0);
    test_reset();
    test_digits();
    test_overflow();
    test_operator();
    test_enable_edge();
    test_clear();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
